// File: rtl/pc_predict_unit_pkg.sv
// Shared Y86-64 instruction codes and default widths for the fetch-PC logic.
package pc_predict_unit_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 64;

  typedef enum logic [3:0] {
    IHALT   = 4'h0,
    INOP    = 4'h1,
    IRRMOVQ = 4'h2,
    IIRMOVQ = 4'h3,
    IRMMOVQ = 4'h4,
    IMRMOVQ = 4'h5,
    IOPQ    = 4'h6,
    IJXX    = 4'h7,
    ICALL   = 4'h8,
    IRET    = 4'h9,
    IPUSHQ  = 4'hA,
    IPOPQ   = 4'hB
  } icode_e;

endpackage

// File: rtl/pc_predict_unit_ras.sv
// Return-address stack: circular buffer; a push when full overwrites the
// oldest entry, a pop when empty is ignored. Clear applies before push/pop.
module return_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             push_data,
  output logic [WIDTH-1:0]             top,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] sp;        // next write slot
  logic [PTR_W-1:0] sp_base;
  logic [PTR_W-1:0] top_idx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_base;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? LAST_IDX : p - 1'b1;
  endfunction

  // Clear is folded in first so that clear+push leaves exactly the pushed entry.
  always_comb begin
    sp_base  = clear ? '0 : sp;
    cnt_base = clear ? '0 : cnt;
    top_idx  = ptr_dec(sp);
  end

  assign top   = mem[top_idx];
  assign count = cnt;

  // Pointer and occupancy update.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp  <= '0;
      cnt <= '0;
    end else if (push) begin
      sp  <= ptr_inc(sp_base);
      cnt <= (cnt_base == FULL) ? FULL : cnt_base + 1'b1;
    end else if (pop && (cnt_base != '0)) begin
      sp  <= ptr_dec(sp_base);
      cnt <= cnt_base - 1'b1;
    end else begin
      sp  <= sp_base;
      cnt <= cnt_base;
    end
  end

  // Entry storage; contents need no reset since count gates their use.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[sp_base] <= push_data;
    end
  end

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch-PC selection and prediction for the pipelined Y86-64 core: chooses
// between predPC and late jXX/ret corrections, predicts ret via a RAS.
module pc_predict_unit
  import pc_predict_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W    = ADDR_W_DEFAULT,
  parameter int unsigned       RAS_DEPTH = 4,
  parameter int unsigned       RAS_EN    = 1,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             F_stall,
  input  logic [3:0]                       f_icode,
  input  logic [ADDR_W-1:0]                f_valC,
  input  logic [ADDR_W-1:0]                f_valP,
  input  logic [3:0]                       M_icode,
  input  logic                             M_Cnd,
  input  logic [ADDR_W-1:0]                M_valA,
  input  logic [3:0]                       W_icode,
  input  logic [ADDR_W-1:0]                W_valM,
  input  logic [ADDR_W-1:0]                W_pred,
  output logic [ADDR_W-1:0]                f_pc,
  output logic [ADDR_W-1:0]                f_pred_target,
  output logic [ADDR_W-1:0]                predPC,
  output logic                             jxx_mispredict,
  output logic                             ret_mispredict,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count
);

  logic [ADDR_W-1:0] ras_top;
  logic              ras_clear;
  logic              ras_push;
  logic              ras_pop;

  // Correction select: the W-stage ret is older, so it overrides an M-stage jXX.
  always_comb begin
    ret_mispredict = (W_icode == IRET) && (W_valM != W_pred);
    jxx_mispredict = !ret_mispredict && (M_icode == IJXX) && !M_Cnd;
    if (ret_mispredict) begin
      f_pc = W_valM;
    end else if (jxx_mispredict) begin
      f_pc = M_valA;
    end else begin
      f_pc = predPC;
    end
  end

  // Next-PC prediction for the instruction fetched this cycle.
  always_comb begin
    f_pred_target = f_valP;
    if ((f_icode == IJXX) || (f_icode == ICALL)) begin
      f_pred_target = f_valC;
    end else if ((f_icode == IRET) && (RAS_EN != 0) && (ras_count != '0)) begin
      f_pred_target = ras_top;
    end
  end

  // Stack controls: any correction flushes; push/pop only when fetch advances.
  always_comb begin
    ras_clear = ret_mispredict || jxx_mispredict;
    ras_push  = !F_stall && (f_icode == ICALL);
    ras_pop   = !F_stall && (f_icode == IRET);
  end

  // Predicted PC register.
  always_ff @(posedge clk) begin
    if (reset) begin
      predPC <= RESET_PC;
    end else if (!F_stall) begin
      predPC <= f_pred_target;
    end
  end

  if (RAS_EN != 0) begin : g_ras
    return_stack #(
      .DEPTH (RAS_DEPTH),
      .WIDTH (ADDR_W)
    ) u_ras (
      .clk       (clk),
      .reset     (reset),
      .clear     (ras_clear),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (f_valP),
      .top       (ras_top),
      .count     (ras_count)
    );
  end else begin : g_no_ras
    assign ras_top   = '0;
    assign ras_count = '0;
  end

endmodule
